rom_dump_sequencer: RTL

- Sequences a full read-out of the selected PROM (IP3601 or IP3604) for the rom_reader_programmer top level. Replaces manual increment/decrement button stepping with an automatic address sweep.
- Per word: drives address and chip select, waits a programmable access time, then latches chip data.
- Presents each word on a valid/ready handshake to a downstream sink (display buffer or serial dumper).

---
 rtl/rom_dump_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/rom_dump_sequencer.sv
// Automatic PROM read-out sequencer for IP3601/IP3604: sweeps every address,
// holds address/CS for the access time, captures each word, hands it off on valid/ready.
module rom_dump_sequencer #(
    parameter int unsigned ACCESS_CYCLES = 4,
    parameter int unsigned ADDR_WIDTH    = 9,
    parameter int unsigned DATA_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  reset_button,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  chip_type,
    input  logic [DATA_WIDTH-1:0] chip_data_port,
    output logic [ADDR_WIDTH-1:0] chip_address_port,
    output logic [1:0]            ip3601_selection_port,
    output logic [3:0]            ip3604_selection_port,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] address_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned           CNT_W     = 8;
    localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_3601 = ADDR_WIDTH'(255);
    localparam logic [ADDR_WIDTH-1:0] LAST_3604 = ADDR_WIDTH'(511);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CAPTURE,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  chip_sel, chip_sel_n;
    logic [ADDR_WIDTH-1:0] addr_n, addr_out_n, last_addr;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  active_n;
    logic [1:0]            sel01_n;
    logic [3:0]            sel04_n;

    // Next-state logic; chip_address_port doubles as the sweep address register.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        chip_sel_n = chip_sel;
        addr_n     = chip_address_port;
        addr_out_n = address_out;
        data_n     = data_out;
        last_addr  = chip_sel ? LAST_3604 : LAST_3601;

        case (state)
            S_IDLE: begin
                if (start) begin
                    chip_sel_n = chip_type;
                    addr_n     = '0;
                    cnt_n      = CNT_LOAD;
                    state_n    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (abort)             state_n = S_IDLE;
                else if (cnt == '0)    state_n = S_CAPTURE;
                else                   cnt_n   = cnt - CNT_W'(1);
            end
            S_CAPTURE: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else begin
                    data_n     = chip_data_port;
                    addr_out_n = chip_address_port;
                    state_n    = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                // Abort wins over both the handshake and reaching the last word.
                if (abort) begin
                    state_n = S_IDLE;
                end else if (data_ready) begin
                    if (chip_address_port == last_addr) begin
                        state_n = S_DONE;
                    end else begin
                        addr_n  = chip_address_port + ADDR_WIDTH'(1);
                        cnt_n   = CNT_LOAD;
                        state_n = S_SETUP;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Selects follow the state being entered; one select bit makes dual assertion impossible.
        active_n = (state_n == S_SETUP) || (state_n == S_CAPTURE) || (state_n == S_OUTPUT);
        sel01_n  = (active_n && !chip_sel_n) ? 2'b00   : 2'b11;
        sel04_n  = (active_n &&  chip_sel_n) ? 4'b0000 : 4'b1111;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_button) begin
            state                 <= S_IDLE;
            cnt                   <= '0;
            chip_sel              <= 1'b0;
            chip_address_port     <= '0;
            address_out           <= '0;
            data_out              <= '0;
            ip3601_selection_port <= 2'b11;
            ip3604_selection_port <= 4'b1111;
            data_valid            <= 1'b0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
        end else begin
            state                 <= state_n;
            cnt                   <= cnt_n;
            chip_sel              <= chip_sel_n;
            chip_address_port     <= addr_n;
            address_out           <= addr_out_n;
            data_out              <= data_n;
            ip3601_selection_port <= sel01_n;
            ip3604_selection_port <= sel04_n;
            data_valid            <= (state_n == S_OUTPUT);
            busy                  <= (state_n != S_IDLE);
            done                  <= (state_n == S_DONE);
        end
    end

endmodule
